clock_divider_prog: RTL and testbench
=====================================

CLOCK_DIVIDER_PROG -- requirements
Module: clock_divider_prog

Interface
REQ-001 SHALL have parameter CNT_W, default 8; width of the divide-ratio value.
REQ-002 SHALL have parameter DEF_DIV, default 2; active ratio after reset.
REQ-003 SHALL have port clk_in, input, 1, the single source clock; all sequential logic is on clk_in.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, run request for the divided clock.
REQ-006 SHALL have port div_val, input, CNT_W, the requested divide ratio N.
REQ-007 SHALL have port div_load, input, 1, a one-cycle strobe that captures div_val.
REQ-008 SHALL have port clk_out, output, 1, the divided clock.
REQ-009 SHALL have port tick, output, 1, a one-cycle pulse on each clk_out rising edge.
REQ-010 SHALL have port div_ack, output, 1, a one-cycle pulse when a captured ratio becomes active.
REQ-011 SHALL have port div_err, output, 1, a one-cycle pulse when an illegal ratio (0 or 1) is captured.

Function
REQ-012 SHALL implement states IDLE, RUN and STOPPING.
REQ-013 SHALL count cnt from 0 to N-1 in RUN and STOPPING, wrapping to 0.
REQ-014 SHALL drive clk_out high for cnt in 0..floor(N/2)-1 and low otherwise, registered on the rising edge of clk_in.
REQ-015 SHALL, when enable is sampled high in IDLE, enter RUN with cnt=0 and clk_out=1 on the next clk_in edge; this gives 1-cycle latency.
REQ-016 SHALL assert tick on the same cycle that clk_out goes from 0 to 1.
REQ-017 SHALL, when enable is sampled low in RUN, move to STOPPING; the current period completes and the block enters IDLE at the edge where cnt wraps to 0.
REQ-018 SHALL, when enable is re-asserted in STOPPING, return to RUN with no gap, short pulse or phase change.
REQ-019 SHALL hold clk_out=0 and cnt=0 in IDLE; no runt pulses are produced on entry to or exit from IDLE.
REQ-020 SHALL, on div_load, register div_val as the pending ratio; a second div_load before it is applied overwrites the pending ratio.
REQ-021 SHALL apply the pending ratio at the next cnt wrap in RUN or STOPPING, or on the next cycle in IDLE, and pulse div_ack on the cycle it is applied.
REQ-022 SHALL apply a div_load that coincides with a wrap cycle at the following wrap, not the current one.
REQ-023 SHALL, when div_val is 0 or 1, capture it as 2 and pulse div_err on the capture cycle.
REQ-024 SHALL accept ratios up to 2^CNT_W-1; cnt arithmetic is CNT_W bits and never overflows.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force state=IDLE, cnt=0, clk_out=0, tick=0, div_ack=0, div_err=0, active ratio=DEF_DIV and pending ratio empty.
REQ-026 SHALL treat reset asserted mid-period as an immediate abort: clk_out drops at once, with no period completion.
REQ-027 SHALL start from IDLE after rst_n deasserts and honour enable on the first subsequent clk_in edge.

Configuration
REQ-028 SHALL use the macro CLK_DIV_ODD_DUTY50_EN.
REQ-029 SHALL, with CLK_DIV_ODD_DUTY50_EN defined, use a falling-edge retimed copy of the high phase so that clk_out for odd N is high for N/2 clk_in cycles and low for N/2 clk_in cycles (50% duty); even N is unchanged.
REQ-030 SHALL, without CLK_DIV_ODD_DUTY50_EN, make odd N high for floor(N/2) cycles and low for ceil(N/2) cycles, using no falling-edge logic.

Structure
REQ-031 SHALL place the state enum, MIN_DIV=2 and the default-ratio constant in package clk_div_pkg.
REQ-032 SHALL implement the falling-edge half-cycle extension as sub-module clk_div_odd_ext, instantiated only under CLK_DIV_ODD_DUTY50_EN.

Verification
REQ-033 SHALL verify reset defaults: DEF_DIV=2, enable=1 after reset -> clk_out toggles every clk_in cycle (period 2), with tick on every second cycle.
REQ-034 SHALL verify a ratio change: load 5 mid-period -> the current period finishes at N=2, div_ack pulses at the wrap, and the next period is 5 cycles (high 2, low 3, or 2.5/2.5 with the macro defined).
REQ-035 SHALL verify stop and restart: drop enable at cnt=1 with N=6 -> clk_out completes 3 high and 3 low cycles, then goes IDLE; re-asserting enable during STOPPING -> continuous 6-cycle periods.
REQ-036 SHALL verify illegal loads: load 0, then load 1 -> each pulses div_err and gives an effective N=2; a load of 255 at CNT_W=8 -> period 255.
REQ-037 SHALL verify mid-run reset: rst_n low during a high phase -> clk_out=0 immediately, and the first clk_out edge comes 1 cycle after enable is sampled post-reset.
REQ-038 SHALL verify a coincident load: div_load on the wrap cycle -> the old ratio is used for one more period and div_ack pulses at the following wrap.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg -- shared definitions for the programmable clock divider.
//   state_t       : divider control states
//   MIN_DIV       : smallest legal divide ratio; smaller requests are raised to it
//   DEF_DIV_RATIO : ratio that is active out of reset
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int MIN_DIV       = 2;
    localparam int DEF_DIV_RATIO = 2;

endpackage

// File: rtl/clk_div_odd_ext.sv
// clk_div_odd_ext -- stretches the high phase of an odd-ratio divided clock by
// half a source cycle, giving 50% duty for odd N.
//   clk_in    in  source clock (the retiming flop runs on its falling edge)
//   rst_n     in  asynchronous active-low reset
//   hi_phase  in  rising-edge registered high phase from the divider
//   odd_ratio in  active ratio is odd
//   clk_out   out hi_phase OR its half-cycle delayed copy (odd ratios only)
module clk_div_odd_ext (
    input  logic clk_in,
    input  logic rst_n,
    input  logic hi_phase,
    input  logic odd_ratio,
    output logic clk_out
);

    logic ext_q;

    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ext_q <= 1'b0;
        end else begin
            ext_q <= hi_phase & odd_ratio;
        end
    end

    // ext_q rises half a cycle after hi_phase and falls half a cycle after it,
    // so the OR never glitches: the two terms always overlap at each transition.
    assign clk_out = hi_phase | ext_q;

endmodule

// File: rtl/clock_divider_prog.sv
// clock_divider_prog -- programmable integer clock divider with graceful stop.
//   clk_in   in  source clock, all sequential logic runs on it
//   rst_n    in  asynchronous active-low reset
//   enable   in  run request for the divided clock
//   div_val  in  requested divide ratio N (CNT_W bits)
//   div_load in  one-cycle strobe capturing div_val as the pending ratio
//   clk_out  out divided clock, high for cnt < floor(N/2)
//   tick     out one-cycle pulse on the cycle clk_out rises
//   div_ack  out one-cycle pulse when a pending ratio becomes active
//   div_err  out one-cycle pulse when a ratio of 0 or 1 was captured (used as 2)
// Build option: define CLK_DIV_ODD_DUTY50_EN to give odd ratios 50% duty via a
// falling-edge retimed copy of the high phase (clk_div_odd_ext).
module clock_divider_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = DEF_DIV_RATIO
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_ack,
    output logic             div_err
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_RATIO = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] DEF_RATIO = CNT_W'((DEF_DIV < MIN_DIV) ? MIN_DIV : DEF_DIV);

    function automatic logic [CNT_W-1:0] legal_ratio(input logic [CNT_W-1:0] req);
        return (req < MIN_RATIO) ? MIN_RATIO : req;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             hi_q, hi_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             wrap;

    // Last count of the current period; the active ratio is never below 2.
    assign wrap = (state_q != IDLE) && (cnt_q == div_q - CNT_ONE);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DEF_RATIO;
            pend_q     <= DEF_RATIO;
            pend_vld_q <= 1'b0;
            hi_q       <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            hi_q       <= hi_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        // Only a ratio pending before this cycle can be applied now, so a load
        // landing on the wrap cycle waits for the following wrap.
        if (pend_vld_q && ((state_q == IDLE) || wrap)) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
        end
        if (div_load) begin
            pend_d     = legal_ratio(div_val);
            pend_vld_d = 1'b1;
            err_d      = (div_val < MIN_RATIO);
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_ONE;
                // A stop request on the last count ends the period right here.
                if (!enable) begin
                    state_d = wrap ? IDLE : STOPPING;
                end
            end
            STOPPING: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_ONE;
                if (enable) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // cnt 0 is always high and cnt N-1 always low for N >= 2, so a period
        // start is exactly the 0->1 transition of the divided clock.
        hi_d   = (state_d != IDLE) && (cnt_d < (div_d >> 1));
        tick_d = (state_d != IDLE) && (cnt_d == '0);
    end

    assign tick    = tick_q;
    assign div_ack = ack_q;
    assign div_err = err_q;

`ifdef CLK_DIV_ODD_DUTY50_EN
    clk_div_odd_ext u_odd_ext (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .hi_phase  (hi_q),
        .odd_ratio (div_q[0]),
        .clk_out   (clk_out)
    );
`else
    assign clk_out = hi_q;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
module tb_clock_divider_prog;

    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 2;

    logic             clk_in   = 1'b0;
    logic             rst_n    = 1'b1;
    logic             enable   = 1'b0;
    logic [CNT_W-1:0] div_val  = '0;
    logic             div_load = 1'b0;
    logic             clk_out, tick, div_ack, div_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: "running" flag, position inside the current period,
    // active ratio and a single pending-ratio slot.
    bit m_run;
    int m_pos;
    int m_n;
    bit m_pend_v;
    int m_pend;
    bit m_ack;
    bit m_err;

    clock_divider_prog #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .enable   (enable),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_ack  (div_ack),
        .div_err  (div_err)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic exp_clk();
        if (!m_run) return 1'b0;
`ifdef CLK_DIV_ODD_DUTY50_EN
        // Sampled just after the rising edge, the stretched half cycle shows
        // up as one extra high sample for odd ratios.
        if ((m_n % 2) == 1 && m_pos == m_n / 2) return 1'b1;
`endif
        return (m_pos < m_n / 2) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        check("clk_out", clk_out, exp_clk());
        check("tick", tick, (m_run && m_pos == 0) ? 1'b1 : 1'b0);
        check("div_ack", div_ack, m_ack);
        check("div_err", div_err, m_err);
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_pos    = 0;
        m_n      = DEF_DIV;
        m_pend_v = 1'b0;
        m_pend   = DEF_DIV;
        m_ack    = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit ld, input int val);
        bit last;
        last  = m_run && (m_pos == m_n - 1);
        m_ack = 1'b0;
        m_err = 1'b0;
        if (m_pend_v && (!m_run || last)) begin
            m_n      = m_pend;
            m_pend_v = 1'b0;
            m_ack    = 1'b1;
        end
        if (ld) begin
            m_err    = (val < 2);
            m_pend   = (val < 2) ? 2 : val;
            m_pend_v = 1'b1;
        end
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (last) begin
            m_pos = 0;
            if (!en) m_run = 1'b0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic step(input bit en, input bit ld, input logic [CNT_W-1:0] val);
        enable   = en;
        div_load = ld;
        div_val  = val;
        @(posedge clk_in);
        cyc++;
        model_edge(en, ld, int'(val));
        #1;
        check_all();
    endtask

    task automatic run_until_pos(input int p);
        int n = 0;
        while (!(m_run && m_pos == p) && n < 600) begin
            step(1'b1, 1'b0, '0);
            n++;
        end
        if (!(m_run && m_pos == p)) begin
            $display("FAIL align: could not reach position %0d", p);
            $fatal(1, "alignment bound expired");
        end
    endtask

    task automatic stop_to_idle();
        int n = 0;
        while (m_run && n < 600) begin
            step(1'b0, 1'b0, '0);
            n++;
        end
    endtask

    // Cycles between two consecutive DUT ticks, both waits bounded.
    task automatic tick_interval(input string tag, input int exp_len);
        int n = 0;
        while (tick !== 1'b1 && n < 600) begin
            step(1'b1, 1'b0, '0);
            n++;
        end
        n = 0;
        do begin
            step(1'b1, 1'b0, '0);
            n++;
        end while (tick !== 1'b1 && n < 600);
        checks++;
        assert (n == exp_len) else begin
            errors++;
            $error("FAIL %s: observed period %0d expected %0d", tag, n, exp_len);
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        #2;
        check_all();
        @(posedge clk_in);
        #1;
        check_all();
        rst_n = 1'b1;

        // Default ratio 2 right after reset.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
        tick_interval("default_period", 2);

        // Load 5 mid-period: the N=2 period finishes, then 5-cycle periods.
        run_until_pos(0);
        step(1'b1, 1'b1, 8'd5);
        step(1'b1, 1'b0, '0);
        tick_interval("n5_period", 5);

        // Ratio 6, stop at cnt=1, then stop/restart inside STOPPING.
        step(1'b1, 1'b1, 8'd6);
        tick_interval("n6_period", 6);
        run_until_pos(1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
        run_until_pos(2);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        tick_interval("n6_resume_a", 6);
        tick_interval("n6_resume_b", 6);

        // Illegal ratios 0 and 1 become 2; then the largest ratio.
        step(1'b1, 1'b1, 8'd0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 8'd1);
        tick_interval("illegal_n2", 2);
        step(1'b1, 1'b1, 8'd255);
        tick_interval("n255_period", 255);

        // Load while idle applies on the next cycle.
        stop_to_idle();
        step(1'b0, 1'b1, 8'd3);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        tick_interval("idle_load_n3", 3);

        // Load on the wrap cycle: one more old period, ack at the next wrap.
        run_until_pos(2);
        step(1'b1, 1'b1, 8'd4);
        tick_interval("coincident_old", 3);
        tick_interval("coincident_new", 4);

        // Reset during a high phase aborts at once.
        step(1'b1, 1'b1, 8'd8);
        tick_interval("n8_period", 8);
        run_until_pos(1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_clk_drop", clk_out, 1'b0);
        check_all();
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        check_all();
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check("post_reset_first_edge", clk_out, 1'b1);
        tick_interval("post_reset_period", 2);

        // Randomized run against the model.
        for (int i = 0; i < 1500; i++) begin
            bit en, ld;
            logic [CNT_W-1:0] v;
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 255))
                                             : CNT_W'($urandom_range(0, 9));
            step(en, ld, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
